// File: rtl/ex_wb_stage_pkg.sv
// Shared ALU/writeback definitions: word and opcode widths, opcode values,
// result classes and the branch-opcode predicate used by decode and writeback.
// Latency: n/a (definitions only). Backpressure: n/a.
package ex_wb_stage_pkg;

  localparam int REG_WORD_LEN = 16;  // Q1.15 word
  localparam int ALU_MODE_LEN = 5;
  localparam int REG_ADDR_LEN = 4;
  localparam int PC_LEN       = 10;

  typedef logic [ALU_MODE_LEN-1:0] alu_op_t;

  localparam alu_op_t ALU_NOP  = 5'd0;
  localparam alu_op_t ALU_ADD  = 5'd1;
  localparam alu_op_t ALU_SUB  = 5'd2;
  localparam alu_op_t ALU_MUL  = 5'd3;
  localparam alu_op_t ALU_AND  = 5'd4;
  localparam alu_op_t ALU_OR   = 5'd5;
  localparam alu_op_t ALU_XOR  = 5'd6;
  localparam alu_op_t ALU_NOT  = 5'd7;
  localparam alu_op_t ALU_SHL  = 5'd8;
  localparam alu_op_t ALU_SHR  = 5'd9;
  localparam alu_op_t ALU_BEZ  = 5'd10;
  localparam alu_op_t ALU_BNEZ = 5'd11;
  localparam alu_op_t ALU_BEQ  = 5'd12;

  // How the writeback stage disposes of one accepted ALU result.
  typedef enum logic [1:0] {
    RES_DROP   = 2'd0,
    RES_WRITE  = 2'd1,
    RES_BRANCH = 2'd2
  } res_class_t;

  function automatic logic is_branch(input alu_op_t op);
    return (op == ALU_BEZ) || (op == ALU_BNEZ) || (op == ALU_BEQ);
  endfunction

endpackage

// File: rtl/wb_queue2.sv
// 2-entry {addr, data} FIFO feeding the register-file write port, with a
// zero-latency forwarding compare across both stored entries.
// Latency: push visible at head one cycle later. Backpressure: can_push is a
// registered "count < 2"; pops only when head valid and wr_ready.
// Ports: push/push_addr/push_data in; wr_ready in; wr_en/wr_addr/wr_data out
// (head entry); can_push out; fwd_addr in; fwd_hit/fwd_data out.
module wb_queue2 #(
  parameter int WORD_LEN = 16,
  parameter int ADDR_LEN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [ADDR_LEN-1:0] push_addr,
  input  logic [WORD_LEN-1:0] push_data,
  input  logic                wr_ready,
  output logic                wr_en,
  output logic [ADDR_LEN-1:0] wr_addr,
  output logic [WORD_LEN-1:0] wr_data,
  output logic                can_push,
  input  logic [ADDR_LEN-1:0] fwd_addr,
  output logic                fwd_hit,
  output logic [WORD_LEN-1:0] fwd_data
);

  logic [ADDR_LEN-1:0] addr_q [2];
  logic [WORD_LEN-1:0] data_q [2];
  logic                head_q;
  logic                tail_q;
  logic [1:0]          count_q;
  logic [1:0]          count_next;
  logic                do_push;
  logic                do_pop;
  logic                old_hit;
  logic                young_hit;

  assign do_pop  = (count_q != 2'd0) && wr_ready;
  // A push arriving while full is refused; upstream already sees can_push low.
  assign do_push = push && (count_q != 2'd2);

  always_comb begin
    count_next = count_q;
    case ({do_push, do_pop})
      2'b10:   count_next = count_q + 2'd1;
      2'b01:   count_next = count_q - 2'd1;
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q[0] <= '0;
      addr_q[1] <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      count_q   <= 2'd0;
      can_push  <= 1'b1;
    end else begin
      if (do_push) begin
        addr_q[tail_q] <= push_addr;
        data_q[tail_q] <= push_data;
        tail_q         <= ~tail_q;
      end
      if (do_pop) begin
        head_q <= ~head_q;
      end
      count_q  <= count_next;
      can_push <= (count_next != 2'd2);
    end
  end

  assign wr_en   = (count_q != 2'd0);
  assign wr_addr = addr_q[head_q];
  assign wr_data = data_q[head_q];

  // The slot behind the head is only live when both entries are occupied;
  // it is the younger write, so it wins when both addresses match.
  assign old_hit   = (count_q != 2'd0) && (addr_q[head_q] == fwd_addr);
  assign young_hit = (count_q == 2'd2) && (addr_q[~head_q] == fwd_addr);

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_addr != '0) begin
      if (young_hit) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[~head_q];
      end else if (old_hit) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[head_q];
      end
    end
  end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute/writeback stage: classifies each ALU result into branch redirect,
// queued register write, or drop; forwards pending writes to operand fetch.
// Latency: write head / redirect pulse one cycle after accept. Backpressure:
// in_ready is registered and low while the 2-entry write queue is full.
// Ports: in_* result input, wr_* register-file write port, redirect_* PC
// redirect pulse, fwd_* bypass lookup, busy = queue non-empty.
module ex_wb_stage
  import ex_wb_stage_pkg::*;
#(
  parameter int WORD_LEN = REG_WORD_LEN,
  parameter int OP_LEN   = ALU_MODE_LEN,
  parameter int ADDR_LEN = 4,
  parameter int PC_LEN   = ex_wb_stage_pkg::PC_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_LEN-1:0]   in_opcode,
  input  logic [WORD_LEN-1:0] in_data,
  input  logic [ADDR_LEN-1:0] in_rd,
  input  logic [PC_LEN-1:0]   in_target,
  output logic                wr_en,
  input  logic                wr_ready,
  output logic [ADDR_LEN-1:0] wr_addr,
  output logic [WORD_LEN-1:0] wr_data,
  output logic                redirect_valid,
  output logic [PC_LEN-1:0]   redirect_pc,
  input  logic [ADDR_LEN-1:0] fwd_addr,
  output logic                fwd_hit,
  output logic [WORD_LEN-1:0] fwd_data,
  output logic                busy
);

  alu_op_t    op;
  res_class_t res_class;
  logic       accept;
  logic       push;
  logic       taken;

  assign op = alu_op_t'(in_opcode);

  // r0 is hardwired zero, so a write aimed at it is simply discarded.
  always_comb begin
    res_class = RES_DROP;
    if (is_branch(op)) begin
      res_class = RES_BRANCH;
    end else if ((op != ALU_NOP) && (in_rd != '0)) begin
      res_class = RES_WRITE;
    end
  end

  assign accept = in_valid && in_ready;
  assign push   = accept && (res_class == RES_WRITE);
  // The ALU leaves the branch condition in the sign bit of its result word.
  assign taken  = accept && (res_class == RES_BRANCH) && in_data[WORD_LEN-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= taken;
      if (taken) begin
        redirect_pc <= in_target;
      end
    end
  end

  wb_queue2 #(
    .WORD_LEN(WORD_LEN),
    .ADDR_LEN(ADDR_LEN)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_addr(in_rd),
    .push_data(in_data),
    .wr_ready (wr_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .can_push (in_ready),
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
  );

  assign busy = wr_en;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Self-checking bench for ex_wb_stage: directed scenarios plus randomized
// traffic compared cycle by cycle against a queue-based reference model.
module tb_ex_wb_stage;
  import ex_wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [15:0] in_data;
  logic [3:0]  in_rd;
  logic [9:0]  in_target;
  logic        wr_en;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic [3:0]  fwd_addr;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic        busy;

  ex_wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_data(in_data), .in_rd(in_rd), .in_target(in_target),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: pending writes oldest-first, plus redirect state.
  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } ent_t;

  ent_t        mq[$];
  bit          m_rdy;
  bit          m_rv;
  logic [9:0]  m_rpc;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdy = 1'b1;
    m_rv  = 1'b0;
    m_rpc = '0;
  endtask

  task automatic check_all();
    logic        hit;
    logic [15:0] fd;
    hit = 1'b0;
    fd  = '0;
    if (fwd_addr != 4'd0) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].a == fwd_addr) begin
          hit = 1'b1;
          fd  = mq[i].d;   // later (younger) match overwrites
        end
      end
    end
    check("wr_en", 32'(wr_en), 32'(mq.size() > 0));
    check("busy", 32'(busy), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("wr_addr", 32'(wr_addr), 32'(mq[0].a));
      check("wr_data", 32'(wr_data), 32'(mq[0].d));
    end
    check("in_ready", 32'(in_ready), 32'(m_rdy));
    check("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    check("redirect_pc", 32'(redirect_pc), 32'(m_rpc));
    check("fwd_hit", 32'(fwd_hit), 32'(hit));
    check("fwd_data", 32'(fwd_data), 32'(fd));
  endtask

  // One clock cycle: apply inputs, check current state, advance model and DUT.
  task automatic step(input logic v, input logic [4:0] op, input logic [15:0] d,
                      input logic [3:0] rd, input logic [9:0] tgt,
                      input logic wrr, input logic [3:0] fa);
    bit acc, br, drop, pop;
    in_valid  = v;
    in_opcode = op;
    in_data   = d;
    in_rd     = rd;
    in_target = tgt;
    wr_ready  = wrr;
    fwd_addr  = fa;
    #1;
    check_all();
    acc  = v && m_rdy;
    br   = (op == ALU_BEZ) || (op == ALU_BNEZ) || (op == ALU_BEQ);
    drop = (op == ALU_NOP) || (!br && rd == 4'd0);
    pop  = (mq.size() > 0) && wrr;
    m_rv = acc && br && d[15];
    if (m_rv) m_rpc = tgt;
    if (pop) void'(mq.pop_front());
    if (acc && !br && !drop) mq.push_back('{a: rd, d: d});
    m_rdy = (mq.size() < 2);
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_redirect"}, 32'(redirect_valid), 32'd0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_wr_en_after"}, 32'(wr_en), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rv, rwr;
    logic [4:0]  rop;
    logic [15:0] rd16;
    logic [3:0]  rrd, rfa;
    logic [9:0]  rtgt;

    rst_n = 1'b0;
    in_valid = 1'b0; in_opcode = '0; in_data = '0; in_rd = '0; in_target = '0;
    wr_ready = 1'b0; fwd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_redirect_pc", 32'(redirect_pc), 32'd0);
    check("rst_fwd_data", 32'(fwd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write
    step(1, ALU_ADD, 16'h1234, 4'd3, 10'd0, 1, 4'd0);
    check("single_wr_en", 32'(wr_en), 32'd1);
    check("single_wr_addr", 32'(wr_addr), 32'd3);
    check("single_wr_data", 32'(wr_data), 32'h1234);
    step(0, ALU_NOP, 16'h0, 4'd0, 10'd0, 1, 4'd0);
    check("single_wr_en_done", 32'(wr_en), 32'd0);
    check("single_busy_done", 32'(busy), 32'd0);

    // Fill and drain, same destination twice
    step(1, ALU_ADD, 16'h0001, 4'd1, 10'd0, 0, 4'd0);
    step(1, ALU_ADD, 16'h0002, 4'd1, 10'd0, 0, 4'd0);
    in_valid = 1'b0;
    fwd_addr = 4'd1;
    #1;
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_fwd_hit", 32'(fwd_hit), 32'd1);
    check("fill_fwd_youngest", 32'(fwd_data), 32'h0002);
    check("fill_head_first", 32'(wr_data), 32'h0001);
    step(0, ALU_NOP, 16'h0, 4'd0, 10'd0, 1, 4'd1);
    check("drain_second", 32'(wr_data), 32'h0002);
    check("drain_in_ready", 32'(in_ready), 32'd1);
    step(0, ALU_NOP, 16'h0, 4'd0, 10'd0, 1, 4'd1);
    check("drain_empty", 32'(busy), 32'd0);

    // Branch taken / not taken, back-to-back taken
    step(1, ALU_BEZ, 16'h8000, 4'd2, 10'h05A, 1, 4'd0);
    check("br_pulse", 32'(redirect_valid), 32'd1);
    check("br_pc", 32'(redirect_pc), 32'h05A);
    check("br_no_write", 32'(wr_en), 32'd0);
    step(0, ALU_NOP, 16'h0, 4'd0, 10'd0, 1, 4'd0);
    check("br_pulse_end", 32'(redirect_valid), 32'd0);
    step(1, ALU_BEZ, 16'h0000, 4'd2, 10'h05A, 1, 4'd0);
    check("br_not_taken", 32'(redirect_valid), 32'd0);
    step(1, ALU_BNEZ, 16'hC000, 4'd0, 10'h111, 1, 4'd0);
    step(1, ALU_BEQ, 16'hFFFF, 4'd0, 10'h222, 1, 4'd0);
    check("br_b2b_pulse", 32'(redirect_valid), 32'd1);
    check("br_b2b_pc", 32'(redirect_pc), 32'h222);

    // Drops
    step(1, ALU_NOP, 16'hFFFF, 4'd5, 10'd0, 1, 4'd0);
    check("drop_nop", 32'(busy), 32'd0);
    step(1, ALU_ADD, 16'h7777, 4'd0, 10'd0, 1, 4'd0);
    check("drop_r0", 32'(wr_en), 32'd0);
    check("drop_fwd_r0", 32'(fwd_hit), 32'd0);

    // Simultaneous push and pop at count 1
    step(1, ALU_ADD, 16'hAAAA, 4'd2, 10'd0, 1, 4'd2);
    check("pp_first", 32'(wr_data), 32'hAAAA);
    step(1, ALU_SUB, 16'hBBBB, 4'd4, 10'd0, 1, 4'd4);
    check("pp_second", 32'(wr_data), 32'hBBBB);
    check("pp_wr_en", 32'(wr_en), 32'd1);
    check("pp_in_ready", 32'(in_ready), 32'd1);
    step(0, ALU_NOP, 16'h0, 4'd0, 10'd0, 1, 4'd0);

    // Reset with two entries queued, then with a pending redirect
    step(1, ALU_ADD, 16'h5555, 4'd5, 10'd0, 0, 4'd0);
    step(1, ALU_ADD, 16'h6666, 4'd6, 10'd0, 0, 4'd0);
    async_reset("rst_full");
    step(1, ALU_ADD, 16'h1111, 4'd7, 10'd0, 0, 4'd7);
    step(1, ALU_BEZ, 16'h8001, 4'd0, 10'h077, 0, 4'd7);
    async_reset("rst_redirect");

    // Randomized traffic; upstream holds its inputs while blocked.
    rv = 0; rop = '0; rd16 = '0; rrd = '0; rtgt = '0;
    for (int i = 0; i < 3000; i++) begin
      if (m_rdy) begin
        rv   = ($urandom_range(0, 3) != 0);
        rop  = 5'($urandom_range(0, 15));
        rd16 = 16'($urandom);
        rrd  = 4'($urandom_range(0, 3));
        rtgt = 10'($urandom);
      end
      rwr = ($urandom_range(0, 2) != 0);
      rfa = 4'($urandom_range(0, 3));
      step(rv, rop, rd16, rrd, rtgt, rwr, rfa);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
